// File: rtl/ibex_csr_shadowed.sv
// Two-phase shadowed CSR: a first write stages a value and an identical second write commits it.
// A complement shadow copy detects storage corruption. Also provides a sticky lock and a saturating error counter.
module ibex_csr_shadowed #(
    parameter int unsigned              Width       = 32,
    parameter logic [Width-1:0]         ResetValue  = '0,
    parameter logic [Width-1:0]         WriteMask   = '1,
    parameter int unsigned              ErrCntWidth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [Width-1:0]       wr_data_i,
    input  logic                   clear_i,
    input  logic                   lock_set_i,
    output logic [Width-1:0]       rd_data_o,
    output logic                   staged_o,
    output logic                   update_err_o,
    output logic                   wr_blocked_o,
    output logic                   storage_err_o,
    output logic                   locked_o,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        STAGED = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [Width-1:0]       committed_q, committed_d;
    logic [Width-1:0]       shadow_q, shadow_d;
    logic [Width-1:0]       staged_q, staged_d;
    logic                   locked_q;
    logic                   update_err_q, update_err_d;
    logic                   wr_blocked_q, wr_blocked_d;
    logic                   storage_err_prev_q;
    logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

    logic [Width-1:0]       eff_data;
    logic                   lock_now;
    logic                   storage_err;
    logic                   err_event;

    // Non-writable bits always carry the committed value forward.
    assign eff_data    = (wr_data_i & WriteMask) | (committed_q & ~WriteMask);
    assign lock_now    = locked_q | lock_set_i;
    assign storage_err = (committed_q != ~shadow_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d      = state_q;
        staged_d     = staged_q;
        committed_d  = committed_q;
        shadow_d     = shadow_q;
        update_err_d = 1'b0;
        wr_blocked_d = lock_now & wr_en_i;

        if (lock_now) begin
            state_d = IDLE;
        end else if (clear_i) begin
            state_d = IDLE;
        end else if (wr_en_i) begin
            unique case (state_q)
                IDLE: begin
                    staged_d = eff_data;
                    state_d  = STAGED;
                end
                STAGED: begin
                    if (eff_data == staged_q) begin
                        committed_d = eff_data;
                        shadow_d    = ~eff_data;
                    end else begin
                        update_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A coincident update error and storage-error rise count as a single increment.
    assign err_event = update_err_d | (storage_err & ~storage_err_prev_q);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_event && (err_cnt_q != {ErrCntWidth{1'b1}})) begin
            err_cnt_d = err_cnt_q + ErrCntWidth'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q            <= IDLE;
            committed_q        <= ResetValue;
            shadow_q           <= ~ResetValue;
            staged_q           <= ResetValue;
            locked_q           <= 1'b0;
            update_err_q       <= 1'b0;
            wr_blocked_q       <= 1'b0;
            storage_err_prev_q <= 1'b0;
            err_cnt_q          <= '0;
        end else begin
            state_q            <= state_d;
            committed_q        <= committed_d;
            shadow_q           <= shadow_d;
            staged_q           <= staged_d;
            locked_q           <= lock_now;
            update_err_q       <= update_err_d;
            wr_blocked_q       <= wr_blocked_d;
            storage_err_prev_q <= storage_err;
            err_cnt_q          <= err_cnt_d;
        end
    end

    assign rd_data_o     = committed_q;
    assign staged_o      = (state_q == STAGED);
    assign update_err_o  = update_err_q;
    assign wr_blocked_o  = wr_blocked_q;
    assign storage_err_o = storage_err;
    assign locked_o      = locked_q;
    assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_ibex_csr_shadowed.sv
// Directed bench for ibex_csr_shadowed: commit, mismatch, masking, clear, lock, shadow corruption,
// counter saturation and asynchronous reset.
module tb_ibex_csr_shadowed;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        clear;
    logic        lock_set;
    logic [31:0] rd_data;
    logic        staged;
    logic        update_err;
    logic        wr_blocked;
    logic        storage_err;
    logic        locked;
    logic [3:0]  err_cnt;

    logic        m_wr_en;
    logic [31:0] m_wr_data;
    logic [31:0] m_rd_data;
    logic        m_staged;
    logic        m_update_err;
    logic        m_wr_blocked;
    logic        m_storage_err;
    logic        m_locked;
    logic [3:0]  m_err_cnt;

    int checks = 0;
    int errors = 0;

    ibex_csr_shadowed dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_en_i      (wr_en),
        .wr_data_i    (wr_data),
        .clear_i      (clear),
        .lock_set_i   (lock_set),
        .rd_data_o    (rd_data),
        .staged_o     (staged),
        .update_err_o (update_err),
        .wr_blocked_o (wr_blocked),
        .storage_err_o(storage_err),
        .locked_o     (locked),
        .err_cnt_o    (err_cnt)
    );

    ibex_csr_shadowed #(.WriteMask(32'h0000_00FF)) dut_mask (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_en_i      (m_wr_en),
        .wr_data_i    (m_wr_data),
        .clear_i      (1'b0),
        .lock_set_i   (1'b0),
        .rd_data_o    (m_rd_data),
        .staged_o     (m_staged),
        .update_err_o (m_update_err),
        .wr_blocked_o (m_wr_blocked),
        .storage_err_o(m_storage_err),
        .locked_o     (m_locked),
        .err_cnt_o    (m_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rd"},     rd_data,           32'h0);
        check({tag, "_staged"}, {31'b0, staged},      32'h0);
        check({tag, "_upd"},    {31'b0, update_err},  32'h0);
        check({tag, "_blk"},    {31'b0, wr_blocked},  32'h0);
        check({tag, "_serr"},   {31'b0, storage_err}, 32'h0);
        check({tag, "_lock"},   {31'b0, locked},      32'h0);
        check({tag, "_cnt"},    {28'b0, err_cnt},     32'h0);
    endtask

    initial begin
        rst_n     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        clear     = 1'b0;
        lock_set  = 1'b0;
        m_wr_en   = 1'b0;
        m_wr_data = '0;
        #1 rst_n = 1'b0;
        #11;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Two identical consecutive writes commit.
        wr_en = 1'b1; wr_data = 32'hA5A5_0001;
        tick();
        check("stage1_staged", {31'b0, staged}, 32'h1);
        check("stage1_rd", rd_data, 32'h0);
        tick();
        wr_en = 1'b0;
        check("commit_rd", rd_data, 32'hA5A5_0001);
        check("commit_staged", {31'b0, staged}, 32'h0);
        check("commit_serr", {31'b0, storage_err}, 32'h0);
        tick();

        // Mismatching second write.
        wr_en = 1'b1; wr_data = 32'h1;
        tick();
        wr_data = 32'h2;
        tick();
        wr_en = 1'b0;
        check("mismatch_upd", {31'b0, update_err}, 32'h1);
        check("mismatch_rd", rd_data, 32'hA5A5_0001);
        check("mismatch_cnt", {28'b0, err_cnt}, 32'h1);
        check("mismatch_idle", {31'b0, staged}, 32'h0);
        wr_en = 1'b1; wr_data = 32'h3;
        tick();
        wr_en = 1'b0;
        check("restage_staged", {31'b0, staged}, 32'h1);
        check("restage_upd_pulse", {31'b0, update_err}, 32'h0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_staged", {31'b0, staged}, 32'h0);

        // clear coinciding with a matching second write wins.
        wr_en = 1'b1; wr_data = 32'h55;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0; wr_en = 1'b0;
        check("clrwr_staged", {31'b0, staged}, 32'h0);
        check("clrwr_rd", rd_data, 32'hA5A5_0001);
        check("clrwr_upd", {31'b0, update_err}, 32'h0);

        // Masked instance: only the low byte is writable.
        m_wr_en = 1'b1; m_wr_data = 32'hFFFF_FFFF;
        tick();
        tick();
        m_wr_en = 1'b0;
        check("mask_rd", m_rd_data, 32'h0000_00FF);

        // Shadow corruption: storage error and one counter increment.
        force dut.shadow_q = 32'h5A5A_FEFE;
        #1;
        check("flip_serr", {31'b0, storage_err}, 32'h1);
        tick();
        check("flip_cnt", {28'b0, err_cnt}, 32'h2);
        tick();
        check("flip_cnt_once", {28'b0, err_cnt}, 32'h2);
        release dut.shadow_q;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 32'hA5A5_0001;
        tick();
        tick();
        wr_en = 1'b0;
        tick();
        check("restore_serr", {31'b0, storage_err}, 32'h0);
        check("restore_cnt", {28'b0, err_cnt}, 32'h2);

        // Twenty update errors saturate the counter.
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_data = 32'h1;
            tick();
            wr_data = 32'h2;
            tick();
        end
        wr_en = 1'b0;
        tick();
        check("sat_cnt", {28'b0, err_cnt}, 32'hF);
        check("sat_rd", rd_data, 32'hA5A5_0001);

        // Lock aborts a staged write and blocks further writes.
        wr_en = 1'b1; wr_data = 32'h10;
        tick();
        wr_en = 1'b0;
        check("lock_pre_staged", {31'b0, staged}, 32'h1);
        lock_set = 1'b1;
        tick();
        lock_set = 1'b0;
        check("lock_staged", {31'b0, staged}, 32'h0);
        check("lock_locked", {31'b0, locked}, 32'h1);
        wr_en = 1'b1; wr_data = 32'h10;
        tick();
        wr_en = 1'b0;
        check("lock_blk", {31'b0, wr_blocked}, 32'h1);
        check("lock_rd", rd_data, 32'hA5A5_0001);
        check("lock_staged2", {31'b0, staged}, 32'h0);
        tick();
        check("lock_blk_pulse", {31'b0, wr_blocked}, 32'h0);
        check("lock_sticky", {31'b0, locked}, 32'h1);

        // Reset clears the lock; then reset mid-stage.
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("unlock_locked", {31'b0, locked}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b1; wr_data = 32'h77;
        tick();
        wr_en = 1'b0;
        check("pre_rst_staged", {31'b0, staged}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        check("midrst_mask_rd", m_rd_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
